// File: rtl/sr_cmd_conditioner.sv
// sr_cmd_conditioner: turns raw asynchronous set/reset request levels into
// clean, conflict-free one-cycle s/r pulses for a downstream SR flop.
// Each input is synchronised, debounced, then edge-detected. The decoder
// guarantees s and r are never high together; reset has priority over set.
// Optional build macro SR_COND_CONFLICT_CNT_EN adds cnt_clr / conflict_cnt,
// a saturating count of suppressed set edges.
module sr_cmd_conditioner #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic set_raw,
    input  logic rst_raw,
    output logic s,
    output logic r,
    output logic conflict,
    output logic q_mirror
`ifdef SR_COND_CONFLICT_CNT_EN
    ,
    input  logic       cnt_clr,
    output logic [7:0] conflict_cnt
`endif
);

    localparam int unsigned CNT_W   = $clog2(DB_CYCLES + 1);
    localparam int unsigned NIN     = 2;
    localparam int unsigned IDX_SET = 0;
    localparam int unsigned IDX_RST = 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [NIN-1:0] raw_c;
    logic [NIN-1:0] lvl_p1_c;
    logic [NIN-1:0] lvl_p2_c;

    assign raw_c = {rst_raw, set_raw};

    // Per-input synchroniser, debounce filter and two-deep level history
    genvar g;
    for (g = 0; g < NIN; g++) begin : g_in
        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        logic [CNT_W-1:0]       cnt_q, cnt_d;
        logic                   lvl_q, lvl_d;
        logic                   lvl_p1_q, lvl_p2_q;
        logic                   y_c;

        assign y_c = sync_q[SYNC_STAGES-1];

        // Shift in the raw level; accept a new synced level only after it held DB_CYCLES
        always_comb begin
            sync_d = {sync_q[SYNC_STAGES-2:0], raw_c[g]};
            lvl_d  = lvl_q;
            cnt_d  = '0;
            if (y_c != lvl_q) begin
                if (cnt_q == CNT_LAST) begin
                    lvl_d = y_c;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        // Input-path state registers
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync_q   <= '0;
                cnt_q    <= '0;
                lvl_q    <= 1'b0;
                lvl_p1_q <= 1'b0;
                lvl_p2_q <= 1'b0;
            end else begin
                sync_q   <= sync_d;
                cnt_q    <= cnt_d;
                lvl_q    <= lvl_d;
                lvl_p1_q <= lvl_q;
                lvl_p2_q <= lvl_p1_q;
            end
        end

        assign lvl_p1_c[g] = lvl_p1_q;
        assign lvl_p2_c[g] = lvl_p2_q;
    end

    logic e_set_c, e_rst_c, lvl_rst_c;
    logic s_q, s_d, r_q, r_d, conflict_q, conflict_d, q_mirror_q, q_mirror_d;

    assign e_set_c   = lvl_p1_c[IDX_SET] & ~lvl_p2_c[IDX_SET];
    assign e_rst_c   = lvl_p1_c[IDX_RST] & ~lvl_p2_c[IDX_RST];
    assign lvl_rst_c = lvl_p1_c[IDX_RST];

    // Pulse decode: reset edge wins, a held reset level blocks set edges
    always_comb begin
        s_d        = 1'b0;
        r_d        = 1'b0;
        conflict_d = 1'b0;
        q_mirror_d = q_mirror_q;
        if (e_rst_c) begin
            r_d        = 1'b1;
            conflict_d = e_set_c;
        end else if (e_set_c) begin
            if (lvl_rst_c) begin
                conflict_d = 1'b1;
            end else begin
                s_d = 1'b1;
            end
        end
        if (s_d) begin
            q_mirror_d = 1'b1;
        end else if (r_d) begin
            q_mirror_d = 1'b0;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
            q_mirror_q <= 1'b0;
        end else begin
            s_q        <= s_d;
            r_q        <= r_d;
            conflict_q <= conflict_d;
            q_mirror_q <= q_mirror_d;
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign conflict = conflict_q;
    assign q_mirror = q_mirror_q;

`ifdef SR_COND_CONFLICT_CNT_EN
    localparam int unsigned CCNT_W = 8;
    localparam logic [CCNT_W-1:0] CCNT_MAX = '1;

    logic [CCNT_W-1:0] ccnt_q, ccnt_d;

    // Saturating conflict counter; clear has priority over an increment
    always_comb begin
        ccnt_d = ccnt_q;
        if (cnt_clr) begin
            ccnt_d = '0;
        end else if (conflict_q && (ccnt_q != CCNT_MAX)) begin
            ccnt_d = ccnt_q + CCNT_W'(1);
        end
    end

    // Conflict counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ccnt_q <= '0;
        end else begin
            ccnt_q <= ccnt_d;
        end
    end

    assign conflict_cnt = ccnt_q;
`endif

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// Self-checking bench for sr_cmd_conditioner: directed scenarios plus random
// stimulus, checked against a history-based behavioural model.
// Build with SR_COND_CONFLICT_CNT_EN defined to also cover the conflict counter.
module tb_sr_cmd_conditioner;

    localparam int unsigned SYNC = 2;
    localparam int unsigned DB   = 4;
    localparam int unsigned LAT  = SYNC + DB + 1;

    logic clk;
    logic reset_n;
    logic set_raw;
    logic rst_raw;
    logic s, r, conflict, q_mirror;
`ifdef SR_COND_CONFLICT_CNT_EN
    logic       cnt_clr;
    logic [7:0] conflict_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    sr_cmd_conditioner #(.SYNC_STAGES(SYNC), .DB_CYCLES(DB)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .set_raw  (set_raw),
        .rst_raw  (rst_raw),
        .s        (s),
        .r        (r),
        .conflict (conflict),
        .q_mirror (q_mirror)
`ifdef SR_COND_CONFLICT_CNT_EN
        ,
        .cnt_clr      (cnt_clr),
        .conflict_cnt (conflict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Raw samples and filtered levels are kept as newest-first histories.
    // A synced level is the raw sample SYNC edges old; the filtered level
    // follows it once it has disagreed for DB consecutive edges; pulses appear
    // two edges after the filtered level changes.
    bit          rq_s[$], rq_r[$], fq_s[$], fq_r[$];
    bit          mf_s, mf_r;
    int unsigned run_s, run_r;
    bit          exp_s, exp_r, exp_c, exp_q;
    int unsigned exp_cnt;
    bit          ys, yr, es, er, lr, ns, nr, nc;

    function automatic bit qat(input bit q[$], input int unsigned idx);
        return (idx < q.size()) ? q[idx] : 1'b0;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rq_s.delete(); rq_r.delete(); fq_s.delete(); fq_r.delete();
            mf_s = 0; mf_r = 0; run_s = 0; run_r = 0;
            exp_s = 0; exp_r = 0; exp_c = 0; exp_q = 0; exp_cnt = 0;
        end else begin
            rq_s.push_front(set_raw);
            rq_r.push_front(rst_raw);
            ys = qat(rq_s, SYNC);
            yr = qat(rq_r, SYNC);
            if (ys != mf_s) begin
                run_s++;
                if (run_s == DB) begin mf_s = ys; run_s = 0; end
            end else run_s = 0;
            if (yr != mf_r) begin
                run_r++;
                if (run_r == DB) begin mf_r = yr; run_r = 0; end
            end else run_r = 0;
            fq_s.push_front(mf_s);
            fq_r.push_front(mf_r);
            es = qat(fq_s, 2) & ~qat(fq_s, 3);
            er = qat(fq_r, 2) & ~qat(fq_r, 3);
            lr = qat(fq_r, 2);
            nr = er;
            ns = es & ~er & ~lr;
            nc = es & (er | lr);
`ifdef SR_COND_CONFLICT_CNT_EN
            if (cnt_clr) exp_cnt = 0;
            else if (exp_c && exp_cnt < 255) exp_cnt++;
`endif
            exp_s = ns; exp_r = nr; exp_c = nc;
            if (ns) exp_q = 1;
            else if (nr) exp_q = 0;
            while (rq_s.size() > 8) void'(rq_s.pop_back());
            while (rq_r.size() > 8) void'(rq_r.pop_back());
            while (fq_s.size() > 8) void'(fq_s.pop_back());
            while (fq_r.size() > 8) void'(fq_r.pop_back());
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        set_raw = 1'b0;
        rst_raw = 1'b0;
`ifdef SR_COND_CONFLICT_CNT_EN
        cnt_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        set_raw = 1'b1;
        rst_raw = 1'b1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({s, r, conflict, q_mirror} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_async got s/r/c/q=%b%b%b%b want 0000", s, r, conflict, q_mirror);
        end
        repeat (2) tick();
        checks++;
        if ({s, r, conflict, q_mirror} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_held got s/r/c/q=%b%b%b%b want 0000", s, r, conflict, q_mirror);
        end
`ifdef SR_COND_CONFLICT_CNT_EN
        checks++;
        if (conflict_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_cnt got %0d want 0", conflict_cnt);
        end
`endif
        apply_reset();
    endtask

    task automatic test_set_pulse();
        int first = -1;
        int pulses = 0;
        int other = 0;
        set_raw = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            checks++;
            if (s !== exp_s || r !== exp_r || conflict !== exp_c || q_mirror !== exp_q) begin
                failures++;
                $display("FAIL set_pulse_model cyc=%0d got %b%b%b%b want %b%b%b%b",
                         c, s, r, conflict, q_mirror, exp_s, exp_r, exp_c, exp_q);
            end
            if (s) begin pulses++; if (first < 0) first = c; end
            if (r || conflict) other++;
        end
        checks++;
        if (pulses != 1 || first != int'(LAT) + 1) begin
            failures++;
            $display("FAIL set_pulse_latency got pulses=%0d at=%0d want 1 at %0d", pulses, first, LAT + 1);
        end
        checks++;
        if (q_mirror !== 1'b1 || other != 0) begin
            failures++;
            $display("FAIL set_pulse_state got q=%b r/c_cycles=%0d want q=1 0", q_mirror, other);
        end
    endtask

    task automatic test_glitch();
        int pulses = 0;
        set_raw = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (c == 12) set_raw = 1'b1;
            if (c == 15) set_raw = 1'b0;
            tick();
            checks++;
            if (s !== exp_s || r !== exp_r || conflict !== exp_c || q_mirror !== exp_q) begin
                failures++;
                $display("FAIL glitch_model cyc=%0d got %b%b%b%b want %b%b%b%b",
                         c, s, r, conflict, q_mirror, exp_s, exp_r, exp_c, exp_q);
            end
            if (s || r || conflict) pulses++;
        end
        checks++;
        if (pulses != 0 || q_mirror !== 1'b1) begin
            failures++;
            $display("FAIL glitch_filtered got pulses=%0d q=%b want 0 q=1", pulses, q_mirror);
        end
    endtask

    task automatic test_conflict_same_edge();
        int r_at = -1;
        int c_at = -1;
        int s_cnt = 0;
        set_raw = 1'b1;
        rst_raw = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            tick();
            checks++;
            if (s !== exp_s || r !== exp_r || conflict !== exp_c || q_mirror !== exp_q) begin
                failures++;
                $display("FAIL same_edge_model cyc=%0d got %b%b%b%b want %b%b%b%b",
                         c, s, r, conflict, q_mirror, exp_s, exp_r, exp_c, exp_q);
            end
            if (r) r_at = c;
            if (conflict) c_at = c;
            if (s) s_cnt++;
        end
        checks++;
        if (r_at != int'(LAT) + 1 || c_at != int'(LAT) + 1 || s_cnt != 0 || q_mirror !== 1'b0) begin
            failures++;
            $display("FAIL same_edge got r_at=%0d c_at=%0d s=%0d q=%b want %0d %0d 0 0",
                     r_at, c_at, s_cnt, q_mirror, LAT + 1, LAT + 1);
        end
        set_raw = 1'b0;
        rst_raw = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_rst_held();
        int s_cnt = 0;
        int c_cnt = 0;
`ifdef SR_COND_CONFLICT_CNT_EN
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        checks++;
        if (conflict_cnt !== 8'd0) begin
            failures++;
            $display("FAIL rst_held_clear got %0d want 0", conflict_cnt);
        end
`endif
        rst_raw = 1'b1;
        repeat (12) tick();
        set_raw = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            tick();
            checks++;
            if (s !== exp_s || r !== exp_r || conflict !== exp_c || q_mirror !== exp_q) begin
                failures++;
                $display("FAIL rst_held_model cyc=%0d got %b%b%b%b want %b%b%b%b",
                         c, s, r, conflict, q_mirror, exp_s, exp_r, exp_c, exp_q);
            end
            if (s) s_cnt++;
            if (conflict) c_cnt++;
        end
        checks++;
        if (s_cnt != 0 || c_cnt != 1 || q_mirror !== 1'b0) begin
            failures++;
            $display("FAIL rst_held got s=%0d conflicts=%0d q=%b want 0 1 0", s_cnt, c_cnt, q_mirror);
        end
`ifdef SR_COND_CONFLICT_CNT_EN
        checks++;
        if (conflict_cnt !== 8'd1) begin
            failures++;
            $display("FAIL rst_held_cnt got %0d want 1", conflict_cnt);
        end
`endif
        set_raw = 1'b0;
        rst_raw = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_reset_mid_debounce();
        int first = -1;
        int pulses = 0;
        set_raw = 1'b1;
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({s, r, conflict, q_mirror} !== 4'b0000) begin
            failures++;
            $display("FAIL mid_reset_async got s/r/c/q=%b%b%b%b want 0000", s, r, conflict, q_mirror);
        end
        repeat (2) tick();
        checks++;
        if ({s, r, conflict, q_mirror} !== 4'b0000) begin
            failures++;
            $display("FAIL mid_reset_held got s/r/c/q=%b%b%b%b want 0000", s, r, conflict, q_mirror);
        end
        reset_n = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            tick();
            checks++;
            if (s !== exp_s || r !== exp_r || conflict !== exp_c || q_mirror !== exp_q) begin
                failures++;
                $display("FAIL mid_reset_model cyc=%0d got %b%b%b%b want %b%b%b%b",
                         c, s, r, conflict, q_mirror, exp_s, exp_r, exp_c, exp_q);
            end
            if (s) begin pulses++; if (first < 0) first = c; end
        end
        checks++;
        if (pulses != 1 || first != int'(LAT) + 1 || q_mirror !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_relaunch got pulses=%0d at=%0d q=%b want 1 at %0d q=1",
                     pulses, first, q_mirror, LAT + 1);
        end
        set_raw = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 4) == 0) set_raw = ~set_raw;
            if ($urandom_range(0, 5) == 0) rst_raw = ~rst_raw;
`ifdef SR_COND_CONFLICT_CNT_EN
            cnt_clr = ($urandom_range(0, 39) == 0);
`endif
            tick();
            checks++;
            if (s !== exp_s || r !== exp_r || conflict !== exp_c || q_mirror !== exp_q || (s & r)) begin
                failures++;
                $display("FAIL random_model cyc=%0d got %b%b%b%b want %b%b%b%b",
                         c, s, r, conflict, q_mirror, exp_s, exp_r, exp_c, exp_q);
            end
`ifdef SR_COND_CONFLICT_CNT_EN
            checks++;
            if (conflict_cnt !== 8'(exp_cnt)) begin
                failures++;
                $display("FAIL random_cnt cyc=%0d got %0d want %0d", c, conflict_cnt, exp_cnt);
            end
`endif
        end
`ifdef SR_COND_CONFLICT_CNT_EN
        cnt_clr = 1'b0;
`endif
        apply_reset();
    endtask

`ifdef SR_COND_CONFLICT_CNT_EN
    task automatic test_conflict_saturate();
        int seen = 0;
        bit hit = 0;
        rst_raw = 1'b1;
        repeat (12) tick();
        for (int k = 0; k < 300; k++) begin
            for (int j = 0; j < 12; j++) begin
                set_raw = (j < 6);
                tick();
                if (conflict) seen++;
            end
        end
        checks++;
        if (seen != 300 || conflict_cnt !== 8'd255) begin
            failures++;
            $display("FAIL saturate got conflicts=%0d cnt=%0d want 300 255", seen, conflict_cnt);
        end
        set_raw = 1'b1;
        for (int c = 0; c < 20 && !hit; c++) begin
            tick();
            if (conflict) hit = 1;
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL clear_vs_conflict_timeout got no conflict within 20 cycles want 1");
        end else begin
            cnt_clr = 1'b1;
            tick();
            cnt_clr = 1'b0;
            checks++;
            if (conflict_cnt !== 8'd0 || exp_cnt != 0) begin
                failures++;
                $display("FAIL clear_wins got %0d want 0", conflict_cnt);
            end
        end
        set_raw = 1'b0;
        rst_raw = 1'b0;
        repeat (12) tick();
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        set_raw = 1'b0;
        rst_raw = 1'b0;
`ifdef SR_COND_CONFLICT_CNT_EN
        cnt_clr = 1'b0;
`endif
        apply_reset();
        test_reset();
        test_set_pulse();
        test_glitch();
        test_conflict_same_edge();
        test_rst_held();
        test_reset_mid_debounce();
        test_random();
`ifdef SR_COND_CONFLICT_CNT_EN
        test_conflict_saturate();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
